// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter
//
// Arbitrates branch-resolution updates from two branch units onto the single
// insertion port of the branch predictor. Requests that cannot cause an
// insertion (not taken, or already owning a predictor entry) are accepted and
// dropped. Same-cycle duplicates with equal source PC are merged. Survivors are
// buffered in an in-order FIFO whose head is issued at one update per cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   IN_flush            discard buffered updates (head still issued this cycle)
//   IN_valid[1:0]       request valid per branch unit
//   IN_branchID/Addr/Dest/Taken/IsJump   request payload per branch unit
//   OUT_ready[1:0]      request accepted when valid & ready (combinational)
//   OUT_branch*         FIFO head presented to the predictor (zero when invalid)
//   OUT_fifoCount       FIFO occupancy
//   OUT_filteredCount   requests dropped by filter or merge (wrapping)
//   OUT_issuedCount     updates issued to the predictor (wrapping)
module bp_update_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ID_BITS    = 6,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              IN_flush,
  input  logic [1:0]                        IN_valid,
  input  logic [1:0][ID_BITS-1:0]           IN_branchID,
  input  logic [1:0][31:0]                  IN_branchAddr,
  input  logic [1:0][31:0]                  IN_branchDest,
  input  logic [1:0]                        IN_branchTaken,
  input  logic [1:0]                        IN_branchIsJump,
  output logic [1:0]                        OUT_ready,
  output logic                              OUT_branchValid,
  output logic [ID_BITS-1:0]                OUT_branchID,
  output logic [31:0]                       OUT_branchAddr,
  output logic [31:0]                       OUT_branchDest,
  output logic                              OUT_branchTaken,
  output logic                              OUT_branchIsJump,
  output logic [$clog2(FIFO_DEPTH):0]       OUT_fifoCount,
  output logic [CNT_BITS-1:0]               OUT_filteredCount,
  output logic [CNT_BITS-1:0]               OUT_issuedCount
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    logic [31:0]        addr;
    logic [31:0]        dest;
    logic               taken;
    logic               jump;
  } entry_t;

  entry_t                mem [FIFO_DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  prio_q, prio_d;
  logic [CNT_BITS-1:0]   filt_q, filt_d;
  logic [CNT_BITS-1:0]   issued_q, issued_d;

  entry_t                in_ent [2];
  logic [1:0]            useful;
  logic                  merge;
  logic [CW-1:0]         free;
  logic [1:0]            ready;
  logic [1:0]            enq;
  logic                  enq_p, enq_o;
  logic [1:0]            enq_n;
  logic [1:0]            filt_inc;
  logic                  deq;
  logic [PW-1:0]         wptr_o;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_ent[i] = '{id:    IN_branchID[i],
                    addr:  IN_branchAddr[i],
                    dest:  IN_branchDest[i],
                    taken: IN_branchTaken[i],
                    jump:  IN_branchIsJump[i]};
      useful[i] = IN_valid[i] & IN_branchTaken[i] & (&IN_branchID[i]);
    end
  end

  assign merge = useful[0] & useful[1] & (IN_branchAddr[0] == IN_branchAddr[1]);
  // Free slots from the registered count only; a same-cycle pop is not credited.
  assign free  = CW'(FIFO_DEPTH) - count_q;

  always_comb begin
    ready = 2'b00;
    if (!rst && !IN_flush) begin
      for (int i = 0; i < 2; i++) begin
        if (IN_valid[i]) begin
          if (!useful[i]) begin
            ready[i] = 1'b1;
          end else if (1'(i) == prio_q) begin
            ready[i] = (free >= CW'(1));
          end else if (merge) begin
            // Merged duplicate: dropped, so it never needs a slot.
            ready[i] = 1'b1;
          end else begin
            ready[i] = (free >= CW'(2)) || ((free == CW'(1)) && !useful[prio_q]);
          end
        end
      end
    end
  end

  assign OUT_ready = ready;

  assign enq_p = useful[prio_q] & ready[prio_q];
  assign enq_o = useful[~prio_q] & ~merge & ready[~prio_q];

  always_comb begin
    enq          = 2'b00;
    enq[prio_q]  = enq_p;
    enq[~prio_q] = enq_o;
  end

  assign enq_n    = {1'b0, enq_p} + {1'b0, enq_o};
  assign filt_inc = {1'b0, IN_valid[0] & ready[0] & ~enq[0]}
                  + {1'b0, IN_valid[1] & ready[1] & ~enq[1]};
  assign deq      = (count_q != '0);
  // The priority input takes the lower slot when both are written.
  assign wptr_o   = enq_p ? wptr_q + PW'(1) : wptr_q;

  always_comb begin
    count_d  = count_q + CW'(enq_n) - CW'(deq);
    wptr_d   = wptr_q + PW'(enq_n);
    rptr_d   = rptr_q + PW'(deq);
    prio_d   = prio_q ^ (enq_p | enq_o);
    filt_d   = filt_q + CNT_BITS'(filt_inc);
    issued_d = issued_q + CNT_BITS'(deq);
    if (IN_flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      prio_q   <= 1'b0;
      filt_q   <= '0;
      issued_q <= '0;
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      prio_q   <= prio_d;
      filt_q   <= filt_d;
      issued_q <= issued_d;
    end
  end

  // Storage needs no reset: reads are gated by count and writes by ready.
  always_ff @(posedge clk) begin
    if (enq_p) mem[wptr_q] <= in_ent[prio_q];
    if (enq_o) mem[wptr_o] <= in_ent[~prio_q];
  end

  entry_t head;
  assign head = deq ? mem[rptr_q] : '0;

  assign OUT_branchValid   = deq;
  assign OUT_branchID      = head.id;
  assign OUT_branchAddr    = head.addr;
  assign OUT_branchDest    = head.dest;
  assign OUT_branchTaken   = head.taken;
  assign OUT_branchIsJump  = head.jump;
  assign OUT_fifoCount     = count_q;
  assign OUT_filteredCount = filt_q;
  assign OUT_issuedCount   = issued_q;

endmodule

// File: tb/tb_bp_update_arbiter.sv
module tb_bp_update_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [1:0]       valid;
  logic [1:0][5:0]  id;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] dest;
  logic [1:0]       taken;
  logic [1:0]       jump;
  logic [1:0]       ready;
  logic             o_valid;
  logic [5:0]       o_id;
  logic [31:0]      o_addr;
  logic [31:0]      o_dest;
  logic             o_taken;
  logic             o_jump;
  logic [2:0]       o_count;
  logic [15:0]      o_filt;
  logic [15:0]      o_iss;

  always #5 clk = ~clk;

  bp_update_arbiter #(.FIFO_DEPTH(4), .ID_BITS(6), .CNT_BITS(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .IN_flush          (flush),
    .IN_valid          (valid),
    .IN_branchID       (id),
    .IN_branchAddr     (addr),
    .IN_branchDest     (dest),
    .IN_branchTaken    (taken),
    .IN_branchIsJump   (jump),
    .OUT_ready         (ready),
    .OUT_branchValid   (o_valid),
    .OUT_branchID      (o_id),
    .OUT_branchAddr    (o_addr),
    .OUT_branchDest    (o_dest),
    .OUT_branchTaken   (o_taken),
    .OUT_branchIsJump  (o_jump),
    .OUT_fifoCount     (o_count),
    .OUT_filteredCount (o_filt),
    .OUT_issuedCount   (o_iss)
  );

  typedef struct {
    logic [5:0]  id;
    logic [31:0] addr;
    logic [31:0] dest;
    logic        taken;
    logic        jump;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic        m_prio;
  logic [15:0] m_filt;
  logic [15:0] m_iss;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; valid = '0; id = '0; addr = '0; dest = '0;
    taken = '0; jump = '0;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [31:0] d,
                     input logic [5:0] bid, input logic tk);
    valid[i] = 1'b1; addr[i] = a; dest[i] = d; id[i] = bid; taken[i] = tk;
    jump[i] = a[2];
  endtask

  // Check the current cycle against the model, advance the model across the
  // clock edge, and return at the following negedge with inputs idle.
  task automatic cycle();
    logic [1:0] use_v, exp_rdy, pushed;
    logic       mrg;
    int         free, p, o;
    ent_t       e, h;
    #1;
    for (int i = 0; i < 2; i++) use_v[i] = valid[i] && taken[i] && (id[i] == 6'h3F);
    mrg  = use_v[0] && use_v[1] && (addr[0] == addr[1]);
    free = 4 - q.size();
    p    = int'(m_prio);
    o    = 1 - p;
    exp_rdy = '0;
    if (!rst && !flush) begin
      for (int i = 0; i < 2; i++) begin
        if (!valid[i]) continue;
        if (!use_v[i])          exp_rdy[i] = 1'b1;
        else if (i == p)        exp_rdy[i] = (free >= 1);
        else if (mrg)           exp_rdy[i] = 1'b1;
        else                    exp_rdy[i] = (free >= 2) || (free == 1 && !use_v[p]);
      end
    end
    h = '{id: '0, addr: '0, dest: '0, taken: 1'b0, jump: 1'b0};
    if (q.size() != 0) h = q[0];
    chk("ready", 64'(ready), 64'(exp_rdy));
    chk("valid", 64'(o_valid), 64'(q.size() != 0));
    chk("id",    64'(o_id),    64'(h.id));
    chk("addr",  64'(o_addr),  64'(h.addr));
    chk("dest",  64'(o_dest),  64'(h.dest));
    chk("taken", 64'(o_taken), 64'(h.taken));
    chk("jump",  64'(o_jump),  64'(h.jump));
    chk("count", 64'(o_count), 64'(q.size()));
    chk("filt",  64'(o_filt),  64'(m_filt));
    chk("iss",   64'(o_iss),   64'(m_iss));
    chk("count_le_depth", 64'(o_count <= 3'd4), 64'd1);
    if (free == 1 && use_v[0] && use_v[1] && !mrg)
      chk("free1_nonprio_ready", 64'(ready[o]), 64'd0);

    if (rst) begin
      q.delete(); m_prio = 1'b0; m_filt = '0; m_iss = '0;
    end else begin
      if (q.size() != 0) begin
        void'(q.pop_front());
        m_iss++;
      end
      if (flush) begin
        q.delete();
      end else begin
        pushed = '0;
        for (int k = 0; k < 2; k++) begin
          int i;
          i = (k == 0) ? p : o;
          if (use_v[i] && exp_rdy[i] && !(mrg && i == o)) begin
            e = '{id: id[i], addr: addr[i], dest: dest[i], taken: taken[i], jump: jump[i]};
            q.push_back(e);
            pushed[i] = 1'b1;
          end
        end
        for (int i = 0; i < 2; i++)
          if (valid[i] && exp_rdy[i] && !pushed[i]) m_filt++;
        if (pushed != 0) m_prio = ~m_prio;
      end
    end
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic drain();
    for (int k = 0; k < 5; k++) cycle();
  endtask

  initial begin
    q.delete(); m_prio = 1'b0; m_filt = '0; m_iss = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset: useful requests must not be accepted.
    rst = 1'b1; req(0, 32'h500, 32'h600, 6'h3F, 1'b1); req(1, 32'h504, 32'h604, 6'h3F, 1'b1);
    #1 chk("rst_ready", 64'(ready), 64'd0);
    cycle();
    cycle();

    // Single request
    req(0, 32'h100, 32'h200, 6'h3F, 1'b1);
    #1 chk("single_ready", 64'(ready[0]), 64'd1);
    cycle();
    chk("single_valid", 64'(o_valid), 64'd1);
    chk("single_addr",  64'(o_addr),  64'h100);
    chk("single_dest",  64'(o_dest),  64'h200);
    cycle();
    chk("single_iss", 64'(o_iss), 64'd1);

    // Filtering
    req(1, 32'h140, 32'h240, 6'h3F, 1'b0);
    cycle();
    chk("filt_nt", 64'(o_filt), 64'd1);
    chk("filt_nt_valid", 64'(o_valid), 64'd0);
    req(1, 32'h144, 32'h244, 6'h05, 1'b1);
    cycle();
    chk("filt_id", 64'(o_filt), 64'd2);

    // Bring prio back to 0
    req(1, 32'h180, 32'h280, 6'h3F, 1'b1);
    cycle();
    drain();

    // Dual requests
    req(0, 32'h10, 32'h11, 6'h3F, 1'b1); req(1, 32'h20, 32'h21, 6'h3F, 1'b1);
    cycle();
    chk("dual0_first", 64'(o_addr), 64'h10);
    cycle();
    chk("dual0_second", 64'(o_addr), 64'h20);
    drain();
    req(0, 32'h30, 32'h31, 6'h3F, 1'b1); req(1, 32'h40, 32'h41, 6'h3F, 1'b1);
    cycle();
    chk("dual1_first", 64'(o_addr), 64'h40);
    cycle();
    chk("dual1_second", 64'(o_addr), 64'h30);
    drain();

    // Merge
    req(0, 32'h80, 32'h90, 6'h3F, 1'b1); req(1, 32'h80, 32'h94, 6'h3F, 1'b1);
    #1 chk("merge_ready", 64'(ready), 64'd3);
    cycle();
    chk("merge_filt", 64'(o_filt), 64'd3);
    chk("merge_dest", 64'(o_dest), 64'h90);
    cycle();
    chk("merge_single", 64'(o_valid), 64'd0);

    // Full / wrap
    for (int k = 0; k < 10; k++) begin
      req(0, 32'h1000 + 32'(8 * k), 32'h2000 + 32'(k), 6'h3F, 1'b1);
      req(1, 32'h1004 + 32'(8 * k), 32'h3000 + 32'(k), 6'h3F, 1'b1);
      cycle();
    end
    drain();

    // Flush
    req(0, 32'h700, 32'h1, 6'h3F, 1'b1); req(1, 32'h704, 32'h2, 6'h3F, 1'b1);
    cycle();
    req(0, 32'h708, 32'h3, 6'h3F, 1'b1); req(1, 32'h70C, 32'h4, 6'h3F, 1'b1);
    cycle();
    chk("flush_fill", 64'(o_count), 64'd3);
    flush = 1'b1; req(0, 32'h710, 32'h5, 6'h3F, 1'b1);
    #1 chk("flush_head", 64'(o_valid), 64'd1);
    cycle();
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_count", 64'(o_count), 64'd0);
    cycle();

    // Reset in place of flush
    req(0, 32'h800, 32'h1, 6'h3F, 1'b1); req(1, 32'h804, 32'h2, 6'h3F, 1'b1);
    cycle();
    req(0, 32'h808, 32'h3, 6'h3F, 1'b1); req(1, 32'h80C, 32'h4, 6'h3F, 1'b1);
    cycle();
    rst = 1'b1; req(0, 32'h810, 32'h5, 6'h3F, 1'b1); req(1, 32'h814, 32'h6, 6'h3F, 1'b0);
    #1 chk("rst2_ready", 64'(ready), 64'd0);
    cycle();
    chk("rst2_valid", 64'(o_valid), 64'd0);
    chk("rst2_count", 64'(o_count), 64'd0);
    chk("rst2_filt",  64'(o_filt),  64'd0);
    chk("rst2_iss",   64'(o_iss),   64'd0);
    // prio must be 0: both useful, input 0 issues first
    req(0, 32'hA0, 32'h1, 6'h3F, 1'b1); req(1, 32'hB0, 32'h2, 6'h3F, 1'b1);
    cycle();
    chk("rst2_prio", 64'(o_addr), 64'hA0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(99) == 0);
      flush = ($urandom_range(24) == 0);
      for (int i = 0; i < 2; i++) begin
        valid[i] = ($urandom_range(3) != 0);
        taken[i] = ($urandom_range(3) != 0);
        id[i]    = ($urandom_range(3) != 0) ? 6'h3F : 6'($urandom_range(62));
        addr[i]  = 32'h400 + 32'($urandom_range(3) * 4);
        dest[i]  = $urandom;
        jump[i]  = 1'($urandom_range(1));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
